poly_horner_eval: RTL
=====================

# poly_horner_eval

Parametrised fixed-point polynomial evaluator for the function-test datapath. It computes y = a_N·x^N + … + a_1·x + a_0 with Horner's method, using one shared multiply-accumulate step per cycle. Degree, word width and fraction width are configurable. Coefficients live in a runtime-writable register file, so one instance can serve cos, exp or any other fitted approximation without re-synthesis. Arithmetic saturates, and a per-evaluation overflow flag is reported.

## Interface
- DEGREE, 4: polynomial degree N; legal range is DEGREE ≥ 1.
- WIDTH, 32: signed word width of x, coefficients and y.
- FRAC, 8: fractional bits; every operand is Q(WIDTH-FRAC).FRAC; legal range is 1 ≤ FRAC < WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  $clog2(DEGREE+1)  coefficient index i (selects a_i).
- coef_data  in  WIDTH  signed coefficient value.
- start  in  1  evaluation request; sampled only in IDLE.
- x_in  in  WIDTH  signed operand; captured on the accept edge.
- busy  out  1  high while an evaluation is in progress.
- done  out  1  one-cycle pulse when y_out/overflow are updated.
- y_out  out  WIDTH  signed result; held until the next done.
- overflow  out  1  one or more saturations occurred in the last evaluation; held with y_out.

## Operation
- Coefficient file: DEGREE+1 registers, each WIDTH bits, all cleared to 0 on reset.
  - A write occurs on any edge with coef_wr=1 while in IDLE and coef_addr ≤ DEGREE.
  - Writes while busy=1 are dropped.
  - Writes with coef_addr > DEGREE are dropped.
- FSM states: IDLE, EVAL.
  - IDLE→EVAL on an edge with start=1.
    - x_reg <= x_in.
    - acc <= coef[DEGREE].
    - idx <= DEGREE-1.
    - ovf_acc <= 0.
    - busy <= 1.
  - In EVAL, each edge performs acc <= sat(trunc(acc·x_reg) + coef[idx]).
    - If idx > 0, idx decrements.
    - If idx = 0, then:
      - y_out <= that result;
      - overflow <= ovf_acc | (this step saturated);
      - done <= 1;
      - busy <= 0;
      - next state is IDLE.
  - start in EVAL is ignored; there is no queueing.
- Arithmetic for each step:
  - product = acc·x_reg as a full 2·WIDTH signed value, in Q·2FRAC format.
  - The product is arithmetic-shifted right by FRAC (floor).
  - The coefficient is sign-extended and added at 2·WIDTH+1 bits.
  - The result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Any clamp sets ovf_acc.
  - A saturated acc feeds the next step unchanged.
- Simultaneous coef_wr and start in IDLE: both take effect. The evaluation uses the pre-write coef[DEGREE] for the initial acc, and the written value for later steps.

## Timing
- Reset values: busy=0, done=0, y_out=0, overflow=0; state IDLE; idx=0, acc=0, x_reg=0.
- Latency:
  - start is accepted at edge E0.
  - busy=1 from E0 to E_DEGREE.
  - done=1 for exactly the cycle following E_DEGREE; this cycle is DEGREE clocks after acceptance.
- Throughput: the FSM is back in IDLE during the done cycle, so a start held high there is accepted at the next edge. Back-to-back throughput is therefore one result per DEGREE+1 cycles.
- y_out and overflow change only on the done edge (and on reset).
- Reset mid-EVAL:
  - The evaluation is aborted immediately.
  - All outputs and the coefficient file return to their reset values.
  - No done pulse is produced.

## Configuration
- POLY_ROUND_EN defined: each step adds 2^(FRAC-1) to the product before the FRAC shift, giving round-half-up.
- POLY_ROUND_EN undefined: the shift is plain floor (truncation toward -∞).
- All other behaviour and timing are identical in both builds.

## Test plan
Settings are DEGREE=4, WIDTH=32, FRAC=8 throughout.
- cos fit:
  - Stimulus: write a0=0x100, a2=0xFFFFFF80, a4=0x0A, all others 0; start with x_in=0x100.
  - Response: done 4 cycles after the accept edge; y_out=0x0000008A; overflow=0.
- Same coefficients, x_in=0x200: y_out=0xFFFFFFA0; overflow=0.
- Saturation:
  - Stimulus: a4=0x00010000, all others 0, x_in=0x00010000.
  - Response: y_out=0x7FFFFFFF; overflow=1. A following run with x_in=0 gives y_out=0 and overflow=0.
- Rounding:
  - Stimulus: a1=0x01, all others 0, x_in=0x80.
  - Response: y_out=0 without POLY_ROUND_EN, y_out=1 with it.
  - With a1=0xFFFFFFFF instead: y_out=0xFFFFFFFF without the macro, y_out=0 with it.
- Handshake:
  - Hold start high for 12 cycles: done pulses every 5 cycles.
  - coef_wr to a0=0x200 while busy is dropped: the next result is unchanged.
  - Assert rst in the third EVAL cycle: busy, done, y_out and overflow go to 0 immediately, and no done pulse follows.

Source files
------------

// File: rtl/poly_horner_eval.sv
// ============================================================================
// Module   : poly_horner_eval
// Brief    : Saturating fixed-point polynomial evaluator (Horner, one MAC/cycle)
//            with runtime-writable coefficients. Build macro: POLY_ROUND_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module poly_horner_eval #(
    parameter int DEGREE = 4,
    parameter int WIDTH  = 32,
    parameter int FRAC   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             coef_wr,
    input  logic [$clog2(DEGREE+1)-1:0]      coef_addr,
    input  logic [WIDTH-1:0]                 coef_data,
    input  logic                             start,
    input  logic [WIDTH-1:0]                 x_in,
    output logic                             busy,
    output logic                             done,
    output logic [WIDTH-1:0]                 y_out,
    output logic                             overflow
);

    localparam int c_aw   = $clog2(DEGREE+1);
    localparam int c_sw   = 2*WIDTH + 2;
    localparam int c_idx0 = DEGREE - 1;
    localparam int c_deg  = DEGREE;

    localparam logic [c_aw:0]           c_deg_ext  = c_deg[c_aw:0];
    localparam logic [c_aw-1:0]         c_idx_init = c_idx0[c_aw-1:0];
    localparam logic signed [c_sw-1:0]  c_max = {{(c_sw-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_sw-1:0]  c_min = {{(c_sw-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef POLY_ROUND_EN
    localparam logic signed [c_sw-1:0]  c_rnd = {{(c_sw-1){1'b0}}, 1'b1} << (FRAC-1);
`else
    localparam logic signed [c_sw-1:0]  c_rnd = '0;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EVAL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_last;

    logic        [WIDTH-1:0]   r_coef [0:DEGREE];
    logic signed [WIDTH-1:0]   r_acc;
    logic signed [WIDTH-1:0]   r_x;
    logic        [c_aw-1:0]    r_idx;
    logic                      r_ovf;
    logic                      r_done;
    logic        [WIDTH-1:0]   r_y;
    logic                      r_overflow;

    logic                      w_coef_we;
    logic        [WIDTH-1:0]   w_coef_sel;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [c_sw-1:0]    w_prod_ext;
    logic signed [c_sw-1:0]    w_rnd;
    logic signed [c_sw-1:0]    w_shift;
    logic signed [c_sw-1:0]    w_sum;
    logic        [WIDTH-1:0]   w_res;
    logic                      w_sat;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_EVAL;
                    w_accept    = 1'b1;
                end
            end
            S_EVAL: begin
                if (r_idx == '0) begin
                    w_state_nxt = S_IDLE;
                    w_last      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- coefficient file ----------------
    assign w_coef_we = coef_wr && (r_state == S_IDLE) && ({1'b0, coef_addr} <= c_deg_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DEGREE; i++) begin
                r_coef[i] <= '0;
            end
        end else if (w_coef_we) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // ---------------- MAC step ----------------
    // Widened to 2*WIDTH+2 so the rounding add and coefficient add never wrap.
    assign w_coef_sel = r_coef[r_idx];
    assign w_prod     = r_acc * r_x;
    assign w_prod_ext = {{2{w_prod[2*WIDTH-1]}}, w_prod};
    assign w_rnd      = w_prod_ext + c_rnd;
    assign w_shift    = w_rnd >>> FRAC;
    assign w_sum      = w_shift + {{(c_sw-WIDTH){w_coef_sel[WIDTH-1]}}, w_coef_sel};

    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        w_sat = 1'b0;
        if (w_sum > c_max) begin
            w_res = {1'b0, {(WIDTH-1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_sum < c_min) begin
            w_res = {1'b1, {(WIDTH-1){1'b0}}};
            w_sat = 1'b1;
        end
    end

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_x        <= '0;
            r_idx      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_y        <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_x   <= x_in;
                r_acc <= r_coef[DEGREE];
                r_idx <= c_idx_init;
                r_ovf <= 1'b0;
            end else if (r_state == S_EVAL) begin
                r_acc <= w_res;
                r_ovf <= r_ovf | w_sat;
                if (r_idx != '0) begin
                    r_idx <= r_idx - c_aw'(1);
                end
            end
            if (w_last) begin
                r_y        <= w_res;
                r_overflow <= r_ovf | w_sat;
            end
        end
    end

    assign busy     = (r_state == S_EVAL);
    assign done     = r_done;
    assign y_out    = r_y;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
